mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- CPU-side memory-access stage (M) plus M/W pipeline register for the P6 pipelined MIPS core.
- Drives the byte-enabled data-memory interface (m_data_*), which is the initiator side of the testbench memory model.
- Extracts and sign/zero-extends load data and presents registered writeback signals (w_grf_*, w_inst_addr) to the GRF and the bench monitor.
- Detects misaligned and out-of-range accesses, suppresses their side effects and reports them.

Parameters:
- DM_WORDS, 3072, data-memory size in 32-bit words; a byte address is in range iff addr < DM_WORDS*4.
- EXC_ADEL, 4, exception code for a bad load address.
- EXC_ADES, 5, exception code for a bad store address.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset: reset==0 clears all state immediately.
- in_valid  in  1  M stage holds a real instruction.
- in_op  in  4  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; 9-15 treated as none.
- in_addr  in  32  effective byte address.
- in_wdata  in  32  store source register value.
- in_pc  in  32  PC of the M-stage instruction.
- in_rd  in  5  destination register.
- in_reg_we  in  1  instruction writes the GRF.
- in_alu_result  in  32  writeback value for non-load ops.
- m_stall  in  1  M stage held this cycle: no store, bubble into W.
- m_flush  in  1  M-stage instruction killed: no store, bubble into W.
- m_data_addr  out  32  equals in_addr (combinational).
- m_data_wdata  out  32  store data, lane-replicated.
- m_data_byteen  out  4  byte write enables.
- m_data_rdata  in  32  word read combinationally at m_data_addr.
- m_inst_addr  out  32  equals in_pc.
- w_grf_we  out  1  registered GRF write enable.
- w_grf_addr  out  5  registered destination.
- w_grf_wdata  out  32  registered writeback data.
- w_inst_addr  out  32  registered PC.
- w_exc  out  1  registered: the instruction in W raised an address exception.
- w_exc_code  out  5  EXC_ADEL or EXC_ADES; 0 when w_exc is 0.
- exc_count  out  8  saturating count of exceptions since reset.

Behaviour:
- Reset: while reset==0, all registered outputs are 0 (w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr, w_exc, w_exc_code, exc_count). Combinational outputs still follow their inputs, except that m_data_byteen is forced to 0.
- live = in_valid & ~m_stall & ~m_flush & reset.
- Alignment:
  - lw/sw require addr[1:0]==0.
  - lh/lhu/sh require addr[0]==0.
  - Byte ops are always aligned.
  - bad = memory op & (misaligned | addr >= DM_WORDS*4).
- Store byte enables, only when live & store & ~bad; otherwise 4'b0000:
  - sw: 4'b1111.
  - sh: 4'b0011 << addr[1:0].
  - sb: 4'b0001 << addr[1:0].
- Store data: sw passes in_wdata; sh replicates in_wdata[15:0] twice; sb replicates in_wdata[7:0] four times.
- Load extraction: select the byte/half from m_data_rdata by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the full word.
- W register update, every rising edge with reset high:
  - If not live: bubble. w_grf_we=0, w_exc=0, w_exc_code=0. w_grf_addr, w_grf_wdata and w_inst_addr hold their previous values.
  - If live and ~bad: w_grf_we = in_reg_we & (in_rd != 0); w_grf_addr = in_rd; w_grf_wdata = extracted load data for loads, else in_alu_result; w_inst_addr = in_pc; w_exc=0.
  - If live and bad: w_grf_we=0; w_inst_addr = in_pc; w_exc=1; w_exc_code = EXC_ADEL for loads, EXC_ADES for stores; exc_count increments, saturating at 255.
- Latency: a load result is visible on w_grf_wdata exactly one cycle after the instruction is live in M. A store reaches memory on the same edge.
- m_stall and m_flush together: treated as flush (bubble, no store).
- Reset asserted mid-store: byteen drops to 0 immediately and no write occurs.
- in_op values 9-15, or 0: no memory access; treated as ALU writeback.

Test Plan:
- Release reset; with in_valid=0, clock 3 cycles -> w_grf_we=0, w_exc=0, exc_count=0, m_data_byteen=0 throughout.
- sw with addr=0x10, wdata=0x12345678, pc=0x3000 -> byteen=1111, wdata=0x12345678. Then lb with addr=0x13, rd=8 -> next cycle w_grf_we=1, w_grf_addr=8, w_grf_wdata=0x00000012; the same access with lbu, rdata=0x87654321 -> 0x00000087, and with lb -> 0xFFFFFF87.
- sh addr=0x6, wdata=0xAAAABEEF -> byteen=1100, wdata=0xBEEFBEEF. lh addr=0x6 with rdata=0x8001xxxx -> w_grf_wdata=0xFFFF8001.
- lw addr=0x2 -> no write, w_exc=1, w_exc_code=4, exc_count=1. Then sw addr=0x3000 (out of range) -> byteen=0000, w_exc_code=5, exc_count=2.
- sb issued with m_stall=1, then again with m_flush=1 -> byteen=0000 in both cycles, W bubble, w_inst_addr unchanged. ALU op with rd=0 -> w_grf_we=0.
- Pull reset low mid-sequence while sw is presented -> byteen=0 at once; all registered outputs clear without waiting for a clock edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access stage and M/W pipeline register for the P6 pipelined MIPS core.
// Drives the byte-enabled data-memory port, extracts load data and flags bad addresses.
module mem_wb_stage #(
  parameter int unsigned DM_WORDS = 3072,
  parameter int unsigned EXC_ADEL = 4,
  parameter int unsigned EXC_ADES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_we,
  input  logic [31:0] in_alu_result,
  input  logic        m_stall,
  input  logic        m_flush,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_inst_addr,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr,
  output logic        w_exc,
  output logic [4:0]  w_exc_code,
  output logic [7:0]  exc_count
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 8;
  localparam logic [AW-1:0] DM_BYTES = AW'(DM_WORDS * 4);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  logic          is_load;
  logic          is_store;
  logic          size_word;
  logic          size_half;
  logic          misaligned;
  logic          out_of_range;
  logic          bad;
  logic          live;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [DW-1:0] load_data;
  logic [3:0]    byteen;
  logic [DW-1:0] store_data;

  logic          grf_we_q,    grf_we_d;
  logic [RW-1:0] grf_addr_q,  grf_addr_d;
  logic [DW-1:0] grf_wdata_q, grf_wdata_d;
  logic [AW-1:0] inst_addr_q, inst_addr_d;
  logic          exc_q,       exc_d;
  logic [4:0]    exc_code_q,  exc_code_d;
  logic [CW-1:0] exc_count_q, exc_count_d;

  // Opcode decode and address legality
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    size_word = 1'b0;
    size_half = 1'b0;
    case (in_op)
      OP_LW:          begin is_load  = 1'b1; size_word = 1'b1; end
      OP_LH, OP_LHU:  begin is_load  = 1'b1; size_half = 1'b1; end
      OP_LB, OP_LBU:  is_load  = 1'b1;
      OP_SW:          begin is_store = 1'b1; size_word = 1'b1; end
      OP_SH:          begin is_store = 1'b1; size_half = 1'b1; end
      OP_SB:          is_store = 1'b1;
      default:        ;
    endcase
    misaligned   = (size_word & (in_addr[1:0] != 2'b00)) | (size_half & in_addr[0]);
    out_of_range = (in_addr >= DM_BYTES);
    bad          = (is_load | is_store) & (misaligned | out_of_range);
    live         = in_valid & ~m_stall & ~m_flush & reset;
  end

  // Load lane selection and extension
  always_comb begin
    rd_byte = m_data_rdata[7:0];
    case (in_addr[1:0])
      2'd0: rd_byte = m_data_rdata[7:0];
      2'd1: rd_byte = m_data_rdata[15:8];
      2'd2: rd_byte = m_data_rdata[23:16];
      2'd3: rd_byte = m_data_rdata[31:24];
      default: ;
    endcase
    rd_half = in_addr[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
    case (in_op)
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'h0000, rd_half};
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'h000000, rd_byte};
      default: load_data = m_data_rdata;
    endcase
  end

  // Store lane enables and replicated data
  always_comb begin
    byteen     = 4'b0000;
    store_data = in_wdata;
    case (in_op)
      OP_SH:   store_data = {2{in_wdata[15:0]}};
      OP_SB:   store_data = {4{in_wdata[7:0]}};
      default: ;
    endcase
    if (live & is_store & ~bad) begin
      case (in_op)
        OP_SW:   byteen = 4'b1111;
        OP_SH:   byteen = 4'b0011 << in_addr[1:0];
        OP_SB:   byteen = 4'b0001 << in_addr[1:0];
        default: byteen = 4'b0000;
      endcase
    end
  end

  // W-register next state: bubbles keep the destination/data/PC fields
  always_comb begin
    grf_we_d    = 1'b0;
    grf_addr_d  = grf_addr_q;
    grf_wdata_d = grf_wdata_q;
    inst_addr_d = inst_addr_q;
    exc_d       = 1'b0;
    exc_code_d  = 5'd0;
    exc_count_d = exc_count_q;
    if (live) begin
      inst_addr_d = in_pc;
      if (bad) begin
        exc_d      = 1'b1;
        exc_code_d = is_load ? 5'(EXC_ADEL) : 5'(EXC_ADES);
        if (exc_count_q != {CW{1'b1}}) begin
          exc_count_d = exc_count_q + CW'(1);
        end
      end else begin
        grf_we_d    = in_reg_we & (in_rd != 5'd0);
        grf_addr_d  = in_rd;
        grf_wdata_d = is_load ? load_data : in_alu_result;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we_q    <= 1'b0;
      grf_addr_q  <= '0;
      grf_wdata_q <= '0;
      inst_addr_q <= '0;
      exc_q       <= 1'b0;
      exc_code_q  <= '0;
      exc_count_q <= '0;
    end else begin
      grf_we_q    <= grf_we_d;
      grf_addr_q  <= grf_addr_d;
      grf_wdata_q <= grf_wdata_d;
      inst_addr_q <= inst_addr_d;
      exc_q       <= exc_d;
      exc_code_q  <= exc_code_d;
      exc_count_q <= exc_count_d;
    end
  end

  assign m_data_addr   = in_addr;
  assign m_data_wdata  = store_data;
  assign m_data_byteen = byteen;
  assign m_inst_addr   = in_pc;
  assign w_grf_we      = grf_we_q;
  assign w_grf_addr    = grf_addr_q;
  assign w_grf_wdata   = grf_wdata_q;
  assign w_inst_addr   = inst_addr_q;
  assign w_exc         = exc_q;
  assign w_exc_code    = exc_code_q;
  assign exc_count     = exc_count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: bench-side data memory, a spec-level reference model
// checked every cycle, and directed vectors with hand-computed expectations.
module tb_mem_wb_stage;

  localparam int DM_WORDS = 3072;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = 4'd0;
  logic [31:0] in_addr = 32'd0;
  logic [31:0] in_wdata = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        in_reg_we = 1'b0;
  logic [31:0] in_alu_result = 32'd0;
  logic        m_stall = 1'b0;
  logic        m_flush = 1'b0;
  logic [31:0] m_data_addr, m_data_wdata, m_data_rdata, m_inst_addr;
  logic [3:0]  m_data_byteen;
  logic        w_grf_we, w_exc;
  logic [4:0]  w_grf_addr, w_exc_code;
  logic [31:0] w_grf_wdata, w_inst_addr;
  logic [7:0]  exc_count;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] dut_mem [0:DM_WORDS-1];
  logic [31:0] ref_mem [0:DM_WORDS-1];

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_pc(in_pc), .in_rd(in_rd), .in_reg_we(in_reg_we),
    .in_alu_result(in_alu_result), .m_stall(m_stall), .m_flush(m_flush),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_data_rdata(m_data_rdata), .m_inst_addr(m_inst_addr), .w_grf_we(w_grf_we),
    .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr),
    .w_exc(w_exc), .w_exc_code(w_exc_code), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  // Bench data memory driven by the DUT port
  assign m_data_rdata = (m_data_addr < 32'(DM_WORDS * 4)) ? dut_mem[m_data_addr[13:2]] : 32'd0;
  always @(posedge clk) begin
    if (m_data_addr < 32'(DM_WORDS * 4)) begin
      for (int b = 0; b < 4; b++)
        if (m_data_byteen[b]) dut_mem[m_data_addr[13:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd6) return 4;
    if (op == 4'd2 || op == 4'd3 || op == 4'd7) return 2;
    return 1;
  endfunction
  function automatic bit op_load(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd5;
  endfunction
  function automatic bit op_store(input logic [3:0] op);
    return op >= 4'd6 && op <= 4'd8;
  endfunction
  function automatic bit addr_bad(input logic [3:0] op, input logic [31:0] a);
    if (!(op_load(op) || op_store(op))) return 1'b0;
    return ((a % op_size(op)) != 0) || (a >= 32'(DM_WORDS * 4));
  endfunction
  function automatic bit model_live();
    return reset && in_valid && !m_stall && !m_flush;
  endfunction
  function automatic logic [3:0] model_be();
    int lane;
    lane = int'(in_addr % 4);
    if (!(model_live() && op_store(in_op) && !addr_bad(in_op, in_addr))) return 4'b0000;
    if (op_size(in_op) == 4) return 4'b1111;
    if (op_size(in_op) == 2) return 4'(3 << lane);
    return 4'(1 << lane);
  endfunction
  function automatic logic [31:0] model_sdata();
    if (in_op == 4'd7) return {in_wdata[15:0], in_wdata[15:0]};
    if (in_op == 4'd8) return {in_wdata[7:0], in_wdata[7:0], in_wdata[7:0], in_wdata[7:0]};
    return in_wdata;
  endfunction
  function automatic logic [31:0] model_load(input logic [31:0] word);
    int unsigned sh, v;
    sh = (in_addr % 4) * 8;
    case (in_op)
      4'd2: begin v = (word >> sh) & 32'hFFFF; return (v >= 32768) ? v - 65536 : v; end
      4'd3: return (word >> sh) & 32'hFFFF;
      4'd4: begin v = (word >> sh) & 32'hFF; return (v >= 128) ? v - 256 : v; end
      4'd5: return (word >> sh) & 32'hFF;
      default: return word;
    endcase
  endfunction

  logic        mw_we, mw_exc, mw_def;
  logic [4:0]  mw_rd, mw_code;
  logic [31:0] mw_wdata, mw_pc;
  int          m_count;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mw_we = 0; mw_exc = 0; mw_def = 1; mw_rd = 0; mw_code = 0;
      mw_wdata = 0; mw_pc = 0; m_count = 0;
    end else begin
      logic [3:0]  be;
      logic [31:0] sd, word;
      be = model_be();
      sd = model_sdata();
      word = (in_addr < 32'(DM_WORDS * 4)) ? ref_mem[in_addr / 4] : 32'd0;
      mw_we = 0; mw_exc = 0; mw_code = 0;
      if (model_live()) begin
        mw_pc = in_pc;
        if (addr_bad(in_op, in_addr)) begin
          mw_exc = 1;
          mw_code = op_load(in_op) ? 5'd4 : 5'd5;
          mw_def = 0;
          if (m_count < 255) m_count++;
        end else begin
          mw_we = in_reg_we && (in_rd != 0);
          mw_rd = in_rd;
          mw_wdata = op_load(in_op) ? model_load(word) : in_alu_result;
          mw_def = 1;
        end
      end
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[in_addr / 4][8*b +: 8] = sd[8*b +: 8];
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("m_data_addr", m_data_addr, in_addr);
    chk("m_inst_addr", m_inst_addr, in_pc);
    chk("byteen", {28'd0, m_data_byteen}, {28'd0, model_be()});
    if (op_store(in_op)) chk("store_wdata", m_data_wdata, model_sdata());
    chk("w_grf_we", {31'd0, w_grf_we}, {31'd0, mw_we});
    chk("w_exc", {31'd0, w_exc}, {31'd0, mw_exc});
    chk("w_exc_code", {27'd0, w_exc_code}, {27'd0, mw_code});
    chk("w_inst_addr", w_inst_addr, mw_pc);
    chk("exc_count", {24'd0, exc_count}, 32'(m_count));
    if (mw_def) begin
      chk("w_grf_addr", {27'd0, w_grf_addr}, {27'd0, mw_rd});
      chk("w_grf_wdata", w_grf_wdata, mw_wdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [4:0] rd, input logic we,
                       input logic [31:0] alu);
    in_valid = 1; in_op = op; in_addr = a; in_wdata = wd; in_pc = pc;
    in_rd = rd; in_reg_we = we; in_alu_result = alu; m_stall = 0; m_flush = 0;
    #1;
  endtask

  int mem_diff;

  initial begin
    for (int i = 0; i < DM_WORDS; i++) begin dut_mem[i] = 0; ref_mem[i] = 0; end
    #12;
    chk("rst_w_grf_we", {31'd0, w_grf_we}, 32'd0);
    chk("rst_byteen", {28'd0, m_data_byteen}, 32'd0);
    @(negedge clk); reset = 1;
    repeat (3) begin
      tick();
      chk("idle_w_grf_we", {31'd0, w_grf_we}, 32'd0);
      chk("idle_w_exc", {31'd0, w_exc}, 32'd0);
      chk("idle_exc_count", {24'd0, exc_count}, 32'd0);
      chk("idle_byteen", {28'd0, m_data_byteen}, 32'd0);
    end

    issue(4'd6, 32'h10, 32'h12345678, 32'h3000, 5'd0, 0, 0);
    chk("sw_byteen", {28'd0, m_data_byteen}, 32'hF);
    chk("sw_wdata", m_data_wdata, 32'h12345678);
    tick();
    issue(4'd4, 32'h13, 0, 32'h3004, 5'd8, 1, 0);
    tick();
    chk("lb_we", {31'd0, w_grf_we}, 32'd1);
    chk("lb_rd", {27'd0, w_grf_addr}, 32'd8);
    chk("lb_data", w_grf_wdata, 32'h00000012);
    chk("lb_pc", w_inst_addr, 32'h3004);
    issue(4'd6, 32'h10, 32'h87654321, 32'h3008, 5'd0, 0, 0);
    tick();
    issue(4'd5, 32'h13, 0, 32'h300C, 5'd9, 1, 0);
    tick();
    chk("lbu_data", w_grf_wdata, 32'h00000087);
    issue(4'd4, 32'h13, 0, 32'h3010, 5'd10, 1, 0);
    tick();
    chk("lb_neg_data", w_grf_wdata, 32'hFFFFFF87);

    issue(4'd7, 32'h6, 32'hAAAABEEF, 32'h3014, 5'd0, 0, 0);
    chk("sh_byteen", {28'd0, m_data_byteen}, 32'hC);
    chk("sh_wdata", m_data_wdata, 32'hBEEFBEEF);
    tick();
    issue(4'd1, 32'h4, 0, 32'h3018, 5'd3, 1, 0);
    tick();
    chk("lw_after_sh", w_grf_wdata, 32'hBEEF0000);
    issue(4'd6, 32'h4, 32'h80011234, 32'h301C, 5'd0, 0, 0);
    tick();
    issue(4'd2, 32'h6, 0, 32'h3020, 5'd11, 1, 0);
    tick();
    chk("lh_data", w_grf_wdata, 32'hFFFF8001);
    issue(4'd3, 32'h6, 0, 32'h3024, 5'd11, 1, 0);
    tick();
    chk("lhu_data", w_grf_wdata, 32'h00008001);
    issue(4'd8, 32'h5, 32'h000000A5, 32'h3028, 5'd0, 0, 0);
    chk("sb_byteen", {28'd0, m_data_byteen}, 32'h2);
    chk("sb_wdata", m_data_wdata, 32'hA5A5A5A5);
    tick();

    issue(4'd1, 32'h2, 0, 32'h3040, 5'd12, 1, 0);
    tick();
    chk("adel_we", {31'd0, w_grf_we}, 32'd0);
    chk("adel_exc", {31'd0, w_exc}, 32'd1);
    chk("adel_code", {27'd0, w_exc_code}, 32'd4);
    chk("adel_count", {24'd0, exc_count}, 32'd1);
    chk("adel_pc", w_inst_addr, 32'h3040);
    issue(4'd6, 32'h3000, 32'h11111111, 32'h3044, 5'd0, 0, 0);
    chk("ades_byteen", {28'd0, m_data_byteen}, 32'd0);
    tick();
    chk("ades_code", {27'd0, w_exc_code}, 32'd5);
    chk("ades_count", {24'd0, exc_count}, 32'd2);
    issue(4'd6, 32'h2FFC, 32'hCAFEF00D, 32'h3048, 5'd0, 0, 0);
    chk("top_sw_byteen", {28'd0, m_data_byteen}, 32'hF);
    tick();
    issue(4'd1, 32'h2FFC, 0, 32'h304C, 5'd13, 1, 0);
    tick();
    chk("top_lw_data", w_grf_wdata, 32'hCAFEF00D);
    chk("top_lw_exc", {31'd0, w_exc}, 32'd0);
    issue(4'd2, 32'h3, 0, 32'h3050, 5'd14, 1, 0);
    tick();
    chk("lh_mis_code", {27'd0, w_exc_code}, 32'd4);
    chk("lh_mis_count", {24'd0, exc_count}, 32'd3);

    issue(4'd8, 32'h20, 32'h77, 32'h3100, 5'd0, 0, 0);
    m_stall = 1; #1;
    chk("stall_byteen", {28'd0, m_data_byteen}, 32'd0);
    tick();
    chk("stall_exc", {31'd0, w_exc}, 32'd0);
    chk("stall_pc", w_inst_addr, 32'h3050);
    m_stall = 0; m_flush = 1; #1;
    chk("flush_byteen", {28'd0, m_data_byteen}, 32'd0);
    tick();
    chk("flush_we", {31'd0, w_grf_we}, 32'd0);
    chk("flush_pc", w_inst_addr, 32'h3050);
    m_stall = 1; #1;
    chk("both_byteen", {28'd0, m_data_byteen}, 32'd0);
    tick();
    chk("both_pc", w_inst_addr, 32'h3050);
    issue(4'd0, 32'h0, 0, 32'h3104, 5'd0, 1, 32'h1234);
    tick();
    chk("rd0_we", {31'd0, w_grf_we}, 32'd0);
    issue(4'd12, 32'h7, 0, 32'h3108, 5'd5, 1, 32'hDEAD);
    chk("op12_byteen", {28'd0, m_data_byteen}, 32'd0);
    tick();
    chk("op12_we", {31'd0, w_grf_we}, 32'd1);
    chk("op12_data", w_grf_wdata, 32'h0000DEAD);
    in_valid = 0; #1;
    tick();
    chk("invalid_we", {31'd0, w_grf_we}, 32'd0);

    for (int i = 0; i < 260; i++) begin
      issue(4'd1, 32'h1, 0, 32'h4000 + 32'(i), 5'd1, 1, 0);
      tick();
    end
    chk("sat_count", {24'd0, exc_count}, 32'd255);

    issue(4'd6, 32'h40, 32'h5A5A5A5A, 32'h5000, 5'd0, 0, 0);
    chk("pre_rst_byteen", {28'd0, m_data_byteen}, 32'hF);
    #1 reset = 0; #1;
    chk("rst_byteen_now", {28'd0, m_data_byteen}, 32'd0);
    chk("rst_exc_count", {24'd0, exc_count}, 32'd0);
    chk("rst_w_pc", w_inst_addr, 32'd0);
    chk("rst_w_wdata", w_grf_wdata, 32'd0);
    tick();
    chk("rst_no_write", dut_mem[16], 32'd0);
    @(negedge clk); reset = 1; in_valid = 0;
    tick();

    mem_diff = 0;
    for (int i = 0; i < DM_WORDS; i++) if (dut_mem[i] !== ref_mem[i]) mem_diff++;
    chk("mem_image_diffs", 32'(mem_diff), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
